// File: rtl/pulse_demodulator.sv
// pulse_demodulator
//   Receive-side detector for the backscatter trigger pulse. Synchronizes and
//   debounces an idle-high line. It then looks for a long high followed by a
//   long low followed by a return high, and measures the low width in clocks.
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-low reset
//   enable        1 = detector runs, 0 = held in IDLE (front end keeps tracking)
//   input_signal  raw line, idle high, asynchronous to clock
//   pulse_valid   one-cycle strobe: accepted pulse
//   pulse_error   one-cycle strobe: rejected pulse
//   error_code    00 none, 01 low too short, 10 low timeout (valid with pulse_error)
//   pulse_width   measured low width, updated with either strobe, held otherwise
//   pulse_count   accepted pulses, wraps modulo 2^16
//   busy          1 while measuring the low phase
module pulse_demodulator #(
   parameter int unsigned HIGH_MIN = 2400,
   parameter int unsigned LOW_MIN  = 60000,
   parameter int unsigned LOW_MAX  = 63000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        input_signal,
   output logic        pulse_valid,
   output logic        pulse_error,
   output logic [1:0]  error_code,
   output logic [15:0] pulse_width,
   output logic [15:0] pulse_count,
   output logic        busy
);

   localparam logic [15:0] HIGH_MIN_C = 16'(HIGH_MIN);
   localparam logic [15:0] LOW_MIN_C  = 16'(LOW_MIN);
   localparam logic [15:0] LOW_MAX_C  = 16'(LOW_MAX);
   localparam logic [3:0]  DB_LAST    = 4'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      IDLE,
      HIGH_COUNT,
      LOW_COUNT
   } state_t;

   logic        sync1, sync2, level;
   logic [3:0]  db_cnt;

   state_t      state, state_n;
   logic [15:0] high_cnt, high_n;
   logic [15:0] low_cnt, low_n;
   logic        valid_n, error_n;
   logic [1:0]  code_n;
   logic [15:0] width_n, count_n;

   // Front end. Both edges take the same 2+DEBOUNCE clocks to reach 'level',
   // so a measured filtered width equals the raw width.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         level  <= 1'b1;
         db_cnt <= '0;
      end else begin
         sync1 <= input_signal;
         sync2 <= sync1;
         if (sync2 != level) begin
            if (db_cnt == DB_LAST) begin
               level  <= sync2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 4'd1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         high_cnt    <= '0;
         low_cnt     <= '0;
         pulse_valid <= 1'b0;
         pulse_error <= 1'b0;
         error_code  <= '0;
         pulse_width <= '0;
         pulse_count <= '0;
      end else begin
         state       <= state_n;
         high_cnt    <= high_n;
         low_cnt     <= low_n;
         pulse_valid <= valid_n;
         pulse_error <= error_n;
         error_code  <= code_n;
         pulse_width <= width_n;
         pulse_count <= count_n;
      end
   end

   always_comb begin
      state_n = state;
      high_n  = high_cnt;
      low_n   = low_cnt;
      valid_n = 1'b0;
      error_n = 1'b0;
      code_n  = 2'b00;
      width_n = pulse_width;
      count_n = pulse_count;

      if (!enable) begin
         state_n = IDLE;
         high_n  = '0;
         low_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (level) begin
                  state_n = HIGH_COUNT;
                  high_n  = 16'd1;
               end
            end
            HIGH_COUNT: begin
               if (level) begin
                  if (high_cnt < HIGH_MIN_C) high_n = high_cnt + 16'd1;
               end else if (high_cnt >= HIGH_MIN_C) begin
                  state_n = LOW_COUNT;
                  low_n   = 16'd1;
               end else begin
                  state_n = IDLE;
                  high_n  = '0;
               end
            end
            LOW_COUNT: begin
               if (!level) begin
                  // Reaching LOW_MAX+1 is detected one step early, when the
                  // count sits at LOW_MAX and the line is still low.
                  if (low_cnt == LOW_MAX_C) begin
                     state_n = IDLE;
                     low_n   = '0;
                     error_n = 1'b1;
                     code_n  = 2'b10;
                     width_n = LOW_MAX_C + 16'd1;
                  end else begin
                     low_n = low_cnt + 16'd1;
                  end
               end else begin
                  // Rising edge: the high that follows restarts the arm count,
                  // so back-to-back pulses each need their own HIGH_MIN.
                  state_n = HIGH_COUNT;
                  high_n  = 16'd1;
                  low_n   = '0;
                  width_n = low_cnt;
                  if (low_cnt >= LOW_MIN_C) begin
                     valid_n = 1'b1;
                     count_n = pulse_count + 16'd1;
                  end else begin
                     error_n = 1'b1;
                     code_n  = 2'b01;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               high_n  = '0;
               low_n   = '0;
            end
         endcase
      end
   end

   assign busy = (state == LOW_COUNT);

endmodule

// File: tb/tb_pulse_demodulator.sv
// tb_pulse_demodulator
//   Self-checking bench for pulse_demodulator using scaled-down timing
//   parameters. Expected strobes come from a table of hand-derived vectors and
//   from a segment-level reference model applied to a random line stream.
module tb_pulse_demodulator;

   localparam int unsigned HM   = 24;
   localparam int unsigned LMIN = 600;
   localparam int unsigned LMAX = 630;
   localparam int unsigned DB   = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        input_signal = 1'b1;
   logic        pulse_valid, pulse_error, busy;
   logic [1:0]  error_code;
   logic [15:0] pulse_width, pulse_count;

   pulse_demodulator #(
      .HIGH_MIN (HM),
      .LOW_MIN  (LMIN),
      .LOW_MAX  (LMAX),
      .DEBOUNCE (DB)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .input_signal (input_signal),
      .pulse_valid  (pulse_valid),
      .pulse_error  (pulse_error),
      .error_code   (error_code),
      .pulse_width  (pulse_width),
      .pulse_count  (pulse_count),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned at;
      bit          valid;
      logic [1:0]  code;
      logic [15:0] width;
   } ev_t;

   typedef struct {
      int unsigned high;
      int unsigned low;
      int unsigned gp;
      int unsigned glen;
      int          kind;    // 0 none, 1 valid, 2 short, 3 timeout
      int unsigned width;
      int unsigned at_off;  // strobe cycle relative to first low sample
   } vec_t;

   typedef struct {
      bit          lvl;
      int unsigned len;
      int unsigned start;
   } seg_t;

   ev_t         got[$];
   ev_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_count = '0;
   logic [15:0] exp_width = '0;
   int unsigned cyc = 0;
   bit          prev_strobe = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (prev_strobe)
         check("quiet_after_strobe", {pulse_valid, pulse_error, error_code}, 0);
      if (pulse_valid || pulse_error) begin
         check("exclusive_strobes", pulse_valid & pulse_error, 0);
         got.push_back(ev_t'{cyc, pulse_valid, error_code, pulse_width});
      end
      prev_strobe = pulse_valid | pulse_error;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic hold(input logic lvl, input int unsigned n, output int unsigned start);
      start = 0;
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clock);
         input_signal = lvl;
         if (i == 0) start = cyc + 1;
      end
   endtask

   task automatic low_phase(input int unsigned l, input int unsigned gp,
                            input int unsigned glen, output int unsigned start);
      start = 0;
      for (int unsigned i = 0; i < l; i++) begin
         @(negedge clock);
         input_signal = (gp != 0 && i >= gp && (i % gp) < glen);
         if (i == 0) start = cyc + 1;
      end
   endtask

   task automatic expect_ev(input int unsigned at, input bit v, input logic [1:0] c,
                            input int unsigned w);
      exp_q.push_back(ev_t'{at, v, c, w[15:0]});
      if (v) exp_count++;
      exp_width = w[15:0];
   endtask

   task automatic compare_events(input string tag);
      int n;
      check({tag, "_events"}, got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_ev%0d_cycle", tag, i), got[i].at, exp_q[i].at);
         check($sformatf("%s_ev%0d_valid", tag, i), got[i].valid, exp_q[i].valid);
         check($sformatf("%s_ev%0d_code", tag, i), got[i].code, exp_q[i].code);
         check($sformatf("%s_ev%0d_width", tag, i), got[i].width, exp_q[i].width);
      end
      check({tag, "_pulse_count"}, pulse_count, exp_count);
      check({tag, "_pulse_width"}, pulse_width, exp_width);
      got.delete();
      exp_q.delete();
   endtask

   // One sequence: high h, low l (optional glitches), then an unarmed
   // short high/low tail that returns the detector to IDLE with the line low.
   task automatic run_entry(input string tag, input vec_t v);
      int unsigned s, e;
      hold(1'b1, v.high, s);
      low_phase(v.low, v.gp, v.glen, e);
      hold(1'b1, 10, s);
      hold(1'b0, 20, s);
      case (v.kind)
         1: expect_ev(e + v.at_off, 1'b1, 2'b00, v.width);
         2: expect_ev(e + v.at_off, 1'b0, 2'b01, v.width);
         3: expect_ev(e + v.at_off, 1'b0, 2'b10, v.width);
         default: ;
      endcase
      @(posedge clock);
      #1;
      compare_events(tag);
   endtask

   vec_t        tbl[12];
   seg_t        raw[$];
   seg_t        flt[$];
   int unsigned st, lt, acc, c, fs, rs;

   initial begin
      tbl[0]  = '{24, 616,  0, 0, 1, 616, 622};
      tbl[1]  = '{10, 616,  0, 0, 0,   0,   0};
      tbl[2]  = '{24, 600,  0, 0, 1, 600, 606};
      tbl[3]  = '{24, 300,  0, 0, 2, 300, 306};
      tbl[4]  = '{24, 630,  0, 0, 1, 630, 636};
      tbl[5]  = '{24, 599,  0, 0, 2, 599, 605};
      tbl[6]  = '{23, 616,  0, 0, 0,   0,   0};
      tbl[7]  = '{24, 616, 50, 3, 1, 616, 622};
      tbl[8]  = '{24, 616, 50, 4, 2,  50,  56};
      tbl[9]  = '{24, 631,  0, 0, 3, 631, 636};
      tbl[10] = '{24, 700,  0, 0, 3, 631, 636};
      tbl[11] = '{25, 610,  0, 0, 1, 610, 616};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_pulse_valid", pulse_valid, 0);
      check("rst_pulse_error", pulse_error, 0);
      check("rst_error_code", error_code, 0);
      check("rst_pulse_width", pulse_width, 0);
      check("rst_pulse_count", pulse_count, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;
      hold(1'b1, 10, st);
      hold(1'b0, 20, st);
      @(posedge clock);
      #1;
      compare_events("preamble");

      for (int i = 0; i < 12; i++) run_entry($sformatf("vec%0d", i), tbl[i]);

      // Line held low after an armed high: one timeout, then silence.
      hold(1'b1, 24, st);
      low_phase(2000, 0, 0, st);
      expect_ev(st + DB + LMAX + 2, 1'b0, 2'b10, LMAX + 1);
      hold(1'b1, 10, rs);
      hold(1'b0, 20, rs);
      @(posedge clock);
      #1;
      compare_events("timeout_hold");

      // enable dropped mid-low and raised while still low: no strobe.
      hold(1'b1, 24, st);
      hold(1'b0, 200, st);
      check("busy_mid_low", busy, 1);
      enable = 1'b0;
      hold(1'b0, 100, st);
      check("busy_disabled", busy, 0);
      check("width_held_disabled", pulse_width, exp_width);
      check("count_held_disabled", pulse_count, exp_count);
      enable = 1'b1;
      hold(1'b0, 316, st);
      hold(1'b1, 10, st);
      hold(1'b0, 20, st);
      @(posedge clock);
      #1;
      compare_events("enable_abort");
      run_entry("after_enable", vec_t'{24, 616, 0, 0, 1, 616, 622});

      // Random line stream against a segment-level model.
      for (int t = 0; t < 30; t++) begin
         raw.push_back(seg_t'{1'b1, $urandom_range(5, 40), 0});
         if ($urandom_range(0, 2) == 0) lt = $urandom_range(595, 635);
         else lt = $urandom_range(300, 700);
         if ($urandom_range(0, 1) == 0) begin
            raw.push_back(seg_t'{1'b0, lt, 0});
         end else begin
            acc = 0;
            while (acc < lt) begin
               c = $urandom_range(60, 250);
               raw.push_back(seg_t'{1'b0, c, 0});
               acc += c;
               if (acc < lt) raw.push_back(seg_t'{1'b1, $urandom_range(1, 5), 0});
            end
         end
      end
      raw.push_back(seg_t'{1'b1, 10, 0});
      raw.push_back(seg_t'{1'b0, 20, 0});
      foreach (raw[k]) begin
         hold(raw[k].lvl, raw[k].len, st);
         raw[k].start = st;
      end
      // Runs shorter than DB vanish into their surroundings.
      foreach (raw[k]) begin
         if (flt.size() > 0 && (raw[k].len < DB || raw[k].lvl == flt[$].lvl))
            flt[$].len += raw[k].len;
         else
            flt.push_back(raw[k]);
      end
      for (int i = 1; i < flt.size(); i++) begin
         if (!flt[i].lvl && flt[i-1].lvl && flt[i-1].len >= HM) begin
            fs = flt[i].start + 1 + DB;
            if (flt[i].len > LMAX) begin
               expect_ev(fs + LMAX + 1, 1'b0, 2'b10, LMAX + 1);
            end else if (i + 1 < flt.size()) begin
               rs = flt[i+1].start + 1 + DB;
               if (flt[i].len >= LMIN) expect_ev(rs + 1, 1'b1, 2'b00, flt[i].len);
               else expect_ev(rs + 1, 1'b0, 2'b01, flt[i].len);
            end
         end
      end
      @(posedge clock);
      #1;
      compare_events("random");

      // Reset asserted mid-low: everything clears, no partial-pulse strobe.
      hold(1'b1, 24, st);
      hold(1'b0, 300, st);
      reset = 1'b0;
      hold(1'b0, 3, st);
      check("midrst_pulse_valid", pulse_valid, 0);
      check("midrst_pulse_error", pulse_error, 0);
      check("midrst_error_code", error_code, 0);
      check("midrst_pulse_width", pulse_width, 0);
      check("midrst_pulse_count", pulse_count, 0);
      check("midrst_busy", busy, 0);
      exp_count = '0;
      exp_width = '0;
      reset = 1'b1;
      hold(1'b0, 50, st);
      hold(1'b1, 10, st);
      hold(1'b0, 20, st);
      @(posedge clock);
      #1;
      compare_events("reset_recover");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_demodulator.md
Name: pulse_demodulator

Overview:
- Receive-side counterpart of the backscatter tag's trigger modulator.
- Watches a single idle-high line and filters it. Checks for a valid "long high, then long low, then high" pulse and measures the low width in clocks.
- Reports each valid pulse and each malformed pulse (one-cycle strobes) to downstream control logic: test harness, loopback checker, or reader-side sequencer.

Parameters:
- HIGH_MIN, 2400, minimum filtered-high cycles required before a falling edge arms low measurement
- LOW_MIN, 60000, shortest accepted low width (cycles)
- LOW_MAX, 63000, longest accepted low width; also the timeout (must be < 65535)
- DEBOUNCE, 4, consecutive stable samples needed to accept a level change (1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = detector runs; 0 = forced to IDLE
- input_signal  in  1  raw line, idle high, asynchronous to clock
- pulse_valid  out  1  one-cycle strobe: accepted pulse
- pulse_error  out  1  one-cycle strobe: rejected pulse
- error_code  out  2  00 none, 01 low too short, 10 low timeout; valid with pulse_error
- pulse_width  out  16  measured low width, updated with either strobe, held otherwise
- pulse_count  out  16  count of accepted pulses, wraps 65535->0
- busy  out  1  1 while in LOW_COUNT

Behaviour:
- Clocking and reset:
  - Single clock domain. reset is asynchronous and active-low.
  - Reset values: all outputs 0, both synchronizer flops 1, filtered level 1, debounce counter 0, state IDLE, internal counters 0.
- Front end:
  - 2-flop synchronizer, then debounce.
  - The filtered level changes only after the synchronized value has differed from it for DEBOUNCE consecutive clocks. Any return to the current level clears the debounce count.
  - Raw-edge to filtered-edge latency = 2+DEBOUNCE clocks, identical for both edges, so measured widths equal raw widths.
  - Glitches shorter than DEBOUNCE clocks are invisible.
- States:
  - IDLE: filtered high -> HIGH_COUNT, high_cnt=1. Otherwise stay.
  - HIGH_COUNT: while high, high_cnt increments, saturating at HIGH_MIN. On filtered falling edge:
    - high_cnt>=HIGH_MIN -> LOW_COUNT, low_cnt=1.
    - Otherwise -> IDLE, no strobe.
  - LOW_COUNT: busy=1; low_cnt increments each filtered-low clock.
    - If low_cnt reaches LOW_MAX+1: pulse_error=1, error_code=10, pulse_width=LOW_MAX+1, -> IDLE.
    - On filtered rising edge with LOW_MIN<=low_cnt<=LOW_MAX: pulse_valid=1, pulse_width=low_cnt, pulse_count+1, -> HIGH_COUNT with high_cnt=1. This permits back-to-back pulses, each requiring its own HIGH_MIN.
    - On filtered rising edge with low_cnt<LOW_MIN: pulse_error=1, error_code=01, pulse_width=low_cnt, -> HIGH_COUNT with high_cnt=1.
- Strobe timing:
  - Strobes are registered and asserted exactly one cycle, on the clock after the filtered edge or timeout is detected.
  - pulse_valid and pulse_error are never both 1.
  - error_code returns to 00 when pulse_error deasserts.
- enable:
  - enable=0 forces IDLE and clears high_cnt and low_cnt.
  - No strobes are issued while enable=0, including an abort mid-pulse.
  - The front end keeps tracking the line so the filtered level is current when enable rises.
  - pulse_count and pulse_width hold their values.
- Reset mid-operation: immediate return to reset values. No strobe is emitted for the partial pulse.
- Widths: all counters are 16-bit unsigned. Comparisons are inclusive as stated. pulse_count wraps modulo 2^16.

Test Plan:
- Reset released, enable=1, line high 2400 clk, low 61601 clk, high -> one pulse_valid, 2+DEBOUNCE+1 clk after raw rising edge; pulse_width=61601, pulse_count=1, error_code=00.
- Line high 1000 clk, low 61601 clk, high -> no strobe, pulse_count unchanged. Then high 2400, low 60000 -> pulse_valid, width 60000.
- High 2400, low 30000, high -> pulse_error, error_code=01, pulse_width=30000. A following high 2400, low 63000 -> pulse_valid, width 63000.
- High 2400, line held low indefinitely -> pulse_error with error_code=10 and pulse_width=63001, then no further strobes until the line goes high and a new sequence starts.
- Valid sequence with 3-clk high glitches injected every 5000 clk of the low phase -> single pulse_valid, width equal to the full low time (glitches ignored). With 4-clk glitches -> short errors or no strobe as the rules dictate; check against a reference model.
- enable dropped at low_cnt=20000, raised 100 clk later while still low -> no strobe. The next complete 2400/61601 sequence -> pulse_valid. reset asserted mid-low -> all outputs 0, pulse_count=0.
